// File: rtl/MemArbPkg.sv
// Shared types for the multicycle memory arbiter (state encoding, owner ids, latency limit).
package MemArbPkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_CPU    = 1'b0,
    OWN_LOADER = 1'b1
  } owner_t;

  localparam int unsigned MAX_LAT = 15;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner select for the two arbiter ports.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise the CPU port has fixed priority.
module arb_picker
  import MemArbPkg::*;
(
  input  logic [1:0] req,
  input  owner_t     rr_last,
  output owner_t     winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = OWN_CPU;
    if (req == 2'b11) begin
      // Tie goes to whichever port did not win last time.
      winner = (rr_last == OWN_CPU) ? OWN_LOADER : OWN_CPU;
    end else if (req[1]) begin
      winner = OWN_LOADER;
    end
  end
`else
  logic unused_rr_last;
  assign unused_rr_last = rr_last;

  always_comb begin
    winner = OWN_CPU;
    if (!req[0] && req[1]) begin
      winner = OWN_LOADER;
    end
  end
`endif

endmodule

// File: rtl/multicyc_mem_arbiter.sv
// Serialises CPU (port 0) and loader (port 1) accesses onto one fixed-latency memory.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed CPU priority.
module multicyc_mem_arbiter
  import MemArbPkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_LD = CW'(MEM_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q;
  owner_t        winner;
  owner_t        rr_last;
  logic [1:0]    req_vec;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          done_pulse;

  assign req_vec = {m1_req, m0_req};

`ifdef MEM_ARB_RR_EN
  owner_t rr_last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= OWN_LOADER;
    end else if (state_q == ISSUE) begin
      rr_last_q <= owner_q;
    end
  end

  assign rr_last = rr_last_q;
`else
  assign rr_last = OWN_LOADER;
`endif

  arb_picker u_picker (
    .req     (req_vec),
    .rr_last (rr_last),
    .winner  (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (|req_vec) begin
          state_d = ISSUE;
          owner_d = winner;
        end
      end
      ISSUE: begin
        count_d = LAT_LD;
        // A one-cycle latency is fully spent by the ISSUE beat itself.
        state_d = (LAT_LD == ONE) ? DONE : WAIT;
      end
      WAIT: begin
        if (count_q != '0) begin
          count_d = count_q - ONE;
        end
        if (count_d <= ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (owner_q == OWN_LOADER) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Direction is frozen at ISSUE so a requester changing m*_we later cannot corrupt rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q <= 1'b0;
    end else if (state_q == ISSUE) begin
      we_q <= sel_we;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & sel_we;
  assign mem_addr  = mem_en ? sel_addr : '0;
  assign mem_wdata = mem_en ? sel_wdata : '0;
  assign busy      = (state_q != IDLE);

  // Reset aborts a transaction at once, including one sitting in DONE.
  assign done_pulse = (state_q == DONE) & ~reset;
  assign m0_done    = done_pulse & (owner_q == OWN_CPU);
  assign m1_done    = done_pulse & (owner_q == OWN_LOADER);

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if ((state_q == DONE) && !we_q) begin
      if (owner_q == OWN_CPU) begin
        m0_rdata <= mem_rdata;
      end else begin
        m1_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_multicyc_mem_arbiter.sv
// Scoreboard bench: four arbiter instances (MEM_LAT 1, 2, 3, 15) against a memory model.
module tb_multicyc_mem_arbiter;

  localparam int NI = 4;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  function automatic int unsigned lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  wire [NI-1:0] fin_all;

  task automatic check(input string name, input int unsigned lat, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (MEM_LAT=%0d): got 0x%0h, want 0x%0h", name, lat, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned L = lat_of(g);

    logic        reset;
    logic [1:0]  req, we, done;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        fin = 1'b0;

    multicyc_mem_arbiter #(
      .AW      (32),
      .DW      (32),
      .MEM_LAT (L)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (req[0]),
      .m0_we     (we[0]),
      .m0_addr   (addr[0]),
      .m0_wdata  (wdata[0]),
      .m0_done   (done[0]),
      .m0_rdata  (rdata[0]),
      .m1_req    (req[1]),
      .m1_we     (we[1]),
      .m1_addr   (addr[1]),
      .m1_wdata  (wdata[1]),
      .m1_done   (done[1]),
      .m1_rdata  (rdata[1]),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
    );

    assign fin_all[g] = fin;

    // Memory macro: words written so far, otherwise a fixed init pattern; read data
    // appears L cycles after the strobe and is random garbage in every other cycle.
    logic [31:0]  ram [256];
    logic [255:0] written = '0;
    logic [31:0]  pipe [16];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
      return written[a[9:2]] ? ram[a[9:2]] : init_word(a);
    endfunction

    always @(posedge clk) begin
      if (mem_en && mem_we) begin
        ram[mem_addr[9:2]]     <= mem_wdata;
        written[mem_addr[9:2]] <= 1'b1;
      end
      pipe[0] <= (mem_en && !mem_we) ? mem_word(mem_addr) : $urandom;
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[L-1];

    // Reference model: architectural memory contents in issue order.
    logic [31:0] model [int unsigned];

    function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (model.exists(a)) return model[a];
      return init_word(a);
    endfunction

    exp_t q0[$];
    exp_t q1[$];

    function automatic exp_t make_exp(input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.we    = w;
      e.addr  = a;
      e.wdata = d;
      e.rdata = '0;
      if (w) model[a] = d;
      else e.rdata = model_rd(a);
      return e;
    endfunction

    // Monitor state.
    logic        inflight;
    int          en_cyc;
    logic [31:0] en_addr, en_wdata;
    logic        en_we;
    logic [31:0] exp_rd [2];
    int          last_done_cyc;
    int          done_log[$];
    int          done_cyc_log[$];

    initial begin
      exp_t e;
      logic have;
      inflight      = 1'b0;
      exp_rd[0]     = '0;
      exp_rd[1]     = '0;
      last_done_cyc = -100;
      en_cyc        = 0;
      forever begin
        @(negedge clk);
        check("m0_rdata", L, rdata[0], exp_rd[0]);
        check("m1_rdata", L, rdata[1], exp_rd[1]);
        if (reset) begin
          check("done_in_reset", L, done, 2'b00);
          q0.delete();
          q1.delete();
          inflight  = 1'b0;
          exp_rd[0] = '0;
          exp_rd[1] = '0;
          continue;
        end
        check("busy", L, busy, mem_en | inflight);
        check("mem_we_qual", L, mem_we & ~mem_en, 1'b0);
        if (!mem_en) check("mem_bus_idle", L, {mem_addr, mem_wdata}, 64'h0);
        check("done_excl", L, {done[0] & done[1], (|done) & mem_en}, 2'b00);
        if (mem_en) begin
          check("en_overlap", L, inflight, 1'b0);
          check("en_pending", L, (q0.size() + q1.size()) != 0, 1'b1);
          check("en_gap", L, (cyc - last_done_cyc) >= 2, 1'b1);
          inflight = 1'b1;
          en_cyc   = cyc;
          en_addr  = mem_addr;
          en_we    = mem_we;
          en_wdata = mem_wdata;
        end
        for (int p = 0; p < 2; p++) begin
          if (done[p]) begin
            have = ((p == 0) ? q0.size() : q1.size()) != 0;
            check("done_expected", L, have, 1'b1);
            if (have) begin
              e = (p == 0) ? q0.pop_front() : q1.pop_front();
              check("done_latency", L, cyc - en_cyc, L);
              check("mem_addr", L, en_addr, e.addr);
              check("mem_we", L, en_we, e.we);
              if (e.we) check("mem_wdata", L, en_wdata, e.wdata);
              else exp_rd[p] = e.rdata;
            end
            inflight      = 1'b0;
            last_done_cyc = cyc;
            done_log.push_back(p);
            done_cyc_log.push_back(cyc);
          end
        end
      end
    end

    // Caller is aligned 1 time unit after a rising edge; returns aligned the same way.
    task automatic do_access(input int p, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic chk_lat);
      exp_t e;
      int   t0;
      logic seen;
      e = make_exp(w, a, d);
      if (p == 0) q0.push_back(e);
      else q1.push_back(e);
      we[p]    = w;
      addr[p]  = a;
      wdata[p] = d;
      req[p]   = 1'b1;
      t0       = cyc;
      seen     = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge clk);
        seen = done[p];
      end
      check("done_timeout", L, seen, 1'b1);
      if (chk_lat && seen) check("req_to_done", L, cyc - t0, 1 + L);
      @(posedge clk);
      #1;
      req[p] = 1'b0;
    endtask

    task automatic wait_issue(output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        seen = mem_en;
      end
    endtask

    task automatic pulse_reset();
      reset = 1'b1;
      req   = 2'b00;
      @(posedge clk);
      #1;
      reset = 1'b0;
    endtask

    initial begin
      logic seen;
      int   n;
      int   exp_port [4];
      exp_t e;
      logic [31:0] a0, a1;
      reset    = 1'b1;
      req      = 2'b00;
      we       = 2'b00;
      addr[0]  = '0;
      addr[1]  = '0;
      wdata[0] = '0;
      wdata[1] = '0;

      @(negedge clk);
      check("rst_ctrl", L, {mem_en, mem_we, busy, done}, 5'b0);
      check("rst_bus", L, {mem_addr, mem_wdata}, 64'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // CPU read, then loader write and read-back.
      do_access(0, 1'b0, 32'h40, 32'h0, 1'b1);
      do_access(1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1);
      do_access(1, 1'b0, 32'h100, 32'h0, 1'b1);
      check("loader_readback", L, rdata[1], 32'hDEAD_BEEF);

      // Both ports requesting continuously for four grants.
      pulse_reset();
      a0 = 32'h80;
      a1 = 32'h280;
      done_log.delete();
      done_cyc_log.delete();
      for (int k = 0; k < 4; k++) begin
        exp_port[k] = RR ? (k % 2) : 0;
        if (exp_port[k] == 0) q0.push_back(make_exp(1'b0, a0, 32'h0));
        else q1.push_back(make_exp(1'b0, a1, 32'h0));
      end
      we      = 2'b00;
      addr[0] = a0;
      addr[1] = a1;
      req     = 2'b11;
      n       = 0;
      for (int i = 0; i < 400 && n < 4; i++) begin
        @(negedge clk);
        if (done != 2'b00) n++;
      end
      @(posedge clk);
      #1;
      req = 2'b00;
      check("tie_grants", L, done_log.size(), 4);
      for (int k = 0; k < done_log.size() && k < 4; k++) begin
        check("tie_order", L, done_log[k], exp_port[k]);
        if (k > 0) check("tie_period", L, done_cyc_log[k] - done_cyc_log[k-1], L + 2);
      end

      // Reset in the cycle after ISSUE aborts the access.
      q0.push_back(make_exp(1'b0, 32'h44, 32'h0));
      we[0]   = 1'b0;
      addr[0] = 32'h44;
      req[0]  = 1'b1;
      wait_issue(seen);
      check("abort_issue_seen", L, seen, 1'b1);
      @(posedge clk);
      #1;
      reset  = 1'b1;
      req[0] = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_idle", L, {busy, mem_en, done}, 4'b0);
      repeat (L + 4) @(negedge clk);
      @(posedge clk);
      #1;
      do_access(0, 1'b0, 32'h48, 32'h0, 1'b1);

      // Requester changes address/direction and drops req mid-transaction.
      e = make_exp(1'b0, 32'h60, 32'h0);
      q0.push_back(e);
      we[0]   = 1'b0;
      addr[0] = 32'h60;
      req[0]  = 1'b1;
      wait_issue(seen);
      check("late_issue_seen", L, seen, 1'b1);
      @(posedge clk);
      #1;
      addr[0]  = 32'h64;
      wdata[0] = $urandom;
      we[0]    = 1'b1;
      req[0]   = 1'b0;
      n        = 0;
      for (int i = 0; i < L + 6; i++) begin
        @(negedge clk);
        if (done[0]) n++;
      end
      check("late_done_once", L, n, 1);
      check("late_rdata", L, rdata[0], e.rdata);
      @(posedge clk);
      #1;

      // Random traffic from both ports in disjoint address halves.
      fork
        begin
          for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) begin
              @(posedge clk);
              #1;
            end
            do_access(0, 1'($urandom_range(0, 1)), {22'd0, 1'b0, 7'($urandom), 2'b00},
                      $urandom, 1'b0);
          end
        end
        begin
          for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) begin
              @(posedge clk);
              #1;
            end
            do_access(1, 1'($urandom_range(0, 1)), {22'd0, 1'b1, 7'($urandom), 2'b00},
                      $urandom, 1'b0);
          end
        end
      join

      repeat (L + 4) @(negedge clk);
      check("queues_drained", L, q0.size() + q1.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (fin_all != {NI{1'b1}} && waited < 50000) begin
      @(posedge clk);
      waited++;
    end
    check("all_finished", 0, fin_all, {NI{1'b1}});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
